// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: shared ALU op codes, default widths and requester port ids.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu: purely combinational 32-bit integer ALU (d1, d2, control -> result).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic [3:0]      control,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = d2[SHW-1:0];
    assign lt_signed   = $signed(d1) < $signed(d2);
    assign lt_unsigned = d1 < d2;

    // Unassigned control codes yield zero.
    always_comb begin
        result = '0;
        case (control)
            ALU_ADD:  result = d1 + d2;
            ALU_SUB:  result = d1 - d2;
            ALU_AND:  result = d1 & d2;
            ALU_OR:   result = d1 | d2;
            ALU_XOR:  result = d1 ^ d2;
            ALU_SLL:  result = d1 << shamt;
            ALU_SRL:  result = d1 >> shamt;
            ALU_SRA:  result = $unsigned($signed(d1) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter: shares one ALU between core (port 0) and aux (port 1) with a
// registered response stage; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_result,

    input  logic             flush
);

    logic             accept_en;
    logic             grant0;
    logic             grant1;
    logic             fire0;
    logic             fire1;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_y;
    logic [TAG_W-1:0] sel_tag;

    // Reset is folded in so no request looks accepted while rst is high.
    assign accept_en = ~rst & ~flush & (~rsp_valid | rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`else
    logic rr_ptr;

    assign grant0 = req0_valid & (~req1_valid | (rr_ptr == PORT_CORE));
    assign grant1 = req1_valid & (~req0_valid | (rr_ptr == PORT_AUX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= PORT_CORE;
        end else if (fire0) begin
            rr_ptr <= PORT_AUX;
        end else if (fire1) begin
            rr_ptr <= PORT_CORE;
        end
    end
`endif

    assign fire0      = accept_en & grant0;
    assign fire1      = accept_en & grant1;
    assign req0_ready = fire0;
    assign req1_ready = fire1;

    always_comb begin
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        sel_tag = '0;
        if (fire0) begin
            alu_op  = req0_op;
            alu_a   = req0_a;
            alu_b   = req0_b;
            sel_tag = req0_tag;
        end else if (fire1) begin
            alu_op  = req1_op;
            alu_a   = req1_a;
            alu_b   = req1_b;
            sel_tag = req1_tag;
        end
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .d1      (alu_a),
        .d2      (alu_b),
        .control (alu_op),
        .result  (alu_y)
    );

    // A load while draining keeps rsp_valid high for full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= PORT_CORE;
            rsp_tag    <= '0;
            rsp_result <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (fire0 | fire1) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= fire1 ? PORT_AUX : PORT_CORE;
            rsp_tag    <= sel_tag;
            rsp_result <= alu_y;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_tag;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_result;
    logic        flush;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.XLEN(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .flush      (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    endtask

    task automatic test_reset();
        // rst already high with both requesters valid
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0h exp 0", rsp_id); end
        checks++; if (rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_rsp_tag got %0h exp 0", rsp_tag); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got %0h exp 0", rsp_result); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %0h exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %0h exp 0", req1_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 4'h0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h0, 32'd5, 32'd3, 4'd2);
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got %0h exp 1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got %0h exp 0", req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0h exp 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got %0h exp 0", rsp_id); end
        checks++; if (rsp_tag !== 4'd2) begin errors++; $display("FAIL single_rsp_tag got %0h exp 2", rsp_tag); end
        checks++; if (rsp_result !== 32'd8) begin errors++; $display("FAIL single_rsp_result got %0h exp 8", rsp_result); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0h exp 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic       exp_id;
        rst = 1'b1; #1; rst = 1'b0;
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h1, 32'd100, 32'd1, 4'd3);
        drive1(1'b1, 4'h2, 32'h0000_00F0, 32'h0000_003C, 4'd9);
        for (int k = 0; k < 4; k++) begin
            exp_id = FIXED ? 1'b0 : k[0];
            #1;
            checks++; if (req0_ready !== ~exp_id) begin errors++; $display("FAIL rr_req0_ready[%0d] got %0h exp %0h", k, req0_ready, ~exp_id); end
            checks++; if (req1_ready !== exp_id) begin errors++; $display("FAIL rr_req1_ready[%0d] got %0h exp %0h", k, req1_ready, exp_id); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %0h exp 1", k, rsp_valid); end
            checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0h exp %0h", k, rsp_id, exp_id); end
            checks++; if (rsp_result !== (exp_id ? 32'h30 : 32'd99)) begin errors++; $display("FAIL rr_rsp_result[%0d] got %0h exp %0h", k, rsp_result, exp_id ? 32'h30 : 32'd99); end
            checks++; if (rsp_tag !== (exp_id ? 4'd9 : 4'd3)) begin errors++; $display("FAIL rr_rsp_tag[%0d] got %0h exp %0h", k, rsp_tag, exp_id ? 4'd9 : 4'd3); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_stall();
        // Round robin leaves the pointer on port 0; fixed priority has no pointer.
        rsp_ready = 1'b1;
        drive1(1'b1, 4'h1, 32'd10, 32'd4, 4'd5);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_load_ready got %0h exp 1", req1_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_result !== 32'd6 || rsp_id !== 1'b1) begin errors++; $display("FAIL stall_load_rsp got %0h/%0h exp 6/1", rsp_result, rsp_id); end
        rsp_ready = 1'b0;
        drive0(1'b1, 4'h0, 32'd1, 32'd1, 4'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0h%0h exp 00", k, req0_ready, req1_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd6 || rsp_tag !== 4'd5 || rsp_id !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got v%0h r%0h t%0h i%0h exp v1 r6 t5 i1", k, rsp_valid, rsp_result, rsp_tag, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_release_ready got %0h%0h exp 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_result !== 32'd2 || rsp_id !== 1'b0 || rsp_tag !== 4'd1) begin errors++; $display("FAIL stall_release_rsp got r%0h i%0h t%0h exp r2 i0 t1", rsp_result, rsp_id, rsp_tag); end
    endtask

    task automatic test_flush();
        // Both ports still valid and a response is held; last grant went to port 0.
        flush = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h%0h exp 00", req0_ready, req1_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid got %0h exp 0", rsp_valid); end
        #1;
        checks++; if (req1_ready !== !FIXED || req0_ready !== FIXED) begin errors++; $display("FAIL flush_ptr_ready got %0h%0h exp %0h%0h", req0_ready, req1_ready, FIXED, !FIXED); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== !FIXED) begin errors++; $display("FAIL flush_after_rsp got v%0h i%0h exp v1 i%0h", rsp_valid, rsp_id, !FIXED); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h0, 32'd7, 32'd7, 4'd4);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd14) begin errors++; $display("FAIL rstmid_pre got v%0h r%0h exp v1 r14", rsp_valid, rsp_result); end
        rsp_ready = 1'b0;
        drive1(1'b1, 4'h3, 32'h1, 32'h2, 4'd8);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (rsp_result !== 32'h0 || rsp_tag !== 4'h0) begin errors++; $display("FAIL rstmid_rsp_data got r%0h t%0h exp r0 t0", rsp_result, rsp_tag); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0h%0h exp 00", req0_ready, req1_ready); end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tie_ready got %0h%0h exp 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'd14 || rsp_tag !== 4'd4) begin errors++; $display("FAIL rstmid_tie_rsp got i%0h r%0h t%0h exp i0 r14 t4", rsp_id, rsp_result, rsp_tag); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [11];
        logic [31:0] as  [11];
        logic [31:0] bs  [11];
        logic [31:0] exs [11];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};
        as  = '{32'hFFFF_FFFF, 32'h0, 32'hFF00_FF00, 32'hF000_0000, 32'hAAAA_AAAA,
                32'h1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        bs  = '{32'h1, 32'h1, 32'h0F0F_0F0F, 32'h0000_000F, 32'hFFFF_FFFF,
                32'h24, 32'h4, 32'h4, 32'h0, 32'h0, 32'h1};
        exs = '{32'h0, 32'hFFFF_FFFF, 32'h0F00_0F00, 32'hF000_000F, 32'h5555_5555,
                32'h10, 32'h0800_0000, 32'hF800_0000, 32'h1, 32'h0, 32'h0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive1(1'b1, ops[i], as[i], bs[i], i[3:0]);
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== exs[i] || rsp_tag !== i[3:0] || rsp_id !== 1'b1) begin
                errors++; $display("FAIL alu_op[%0d] got v%0h r%0h t%0h i%0h exp v1 r%0h t%0h i1", i, rsp_valid, rsp_result, rsp_tag, rsp_id, exs[i], i[3:0]);
            end
        end
        req1_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        drive0(1'b1, 4'h0, 32'h1, 32'h1, 4'h1);
        drive1(1'b1, 4'h0, 32'h2, 32'h2, 4'h2);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_flush();
        test_reset_mid();
        test_alu_ops();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
